// File: rtl/shared_alu_arbiter.sv
// Round-robin arbiter/sequencer time-sharing one external Add and one MultComb
// among NREQ requesters; one operation in flight, results returned with requester id.
module shared_alu_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ-1:0]       req_op,
  input  logic [NREQ*WIDTH-1:0] req_left,
  input  logic [NREQ*WIDTH-1:0] req_right,
  output logic                  alu_go,
  output logic [WIDTH-1:0]      alu_left,
  output logic [WIDTH-1:0]      alu_right,
  input  logic [WIDTH-1:0]      alu_add_out,
  input  logic [WIDTH-1:0]      alu_mul_out,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [IDW-1:0]        resp_id,
  output logic [WIDTH-1:0]      resp_data
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t         state, state_n;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] id_q;
  logic           op_q;
  logic           found;
  logic [IDW-1:0] grant;
  logic [IDW-1:0] cand;
  logic [IDW-1:0] next_ptr;

  // Search starts at ptr and wraps; first valid requester wins.
  always_comb begin
    found = 1'b0;
    grant = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IDW'((int'(ptr) + k) % NREQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        grant = cand;
      end
    end
  end

  assign next_ptr = (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    req_ready = '0;
    alu_go    = 1'b0;
    case (state)
      IDLE: begin
        if (found && !reset) begin
          req_ready = NREQ'(1) << grant;
          state_n   = EXEC;
        end
      end
      EXEC: begin
        alu_go  = !reset;
        state_n = RESP;
      end
      RESP: begin
        if (resp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr        <= '0;
      id_q       <= '0;
      op_q       <= 1'b0;
      alu_left   <= '0;
      alu_right  <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            op_q      <= req_op[grant];
            id_q      <= grant;
            alu_left  <= req_left[grant*WIDTH +: WIDTH];
            alu_right <= req_right[grant*WIDTH +: WIDTH];
            ptr       <= next_ptr;
          end
        end
        EXEC: begin
          resp_data  <= op_q ? alu_mul_out : alu_add_out;
          resp_id    <= id_q;
          resp_valid <= 1'b1;
        end
        RESP: begin
          if (resp_ready) resp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shared_alu_arbiter.sv
// Scoreboard bench for shared_alu_arbiter with behavioural Add/MultComb models.
module tb_shared_alu_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 32;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req_valid, req_ready, req_op;
  logic [NREQ*WIDTH-1:0] req_left, req_right;
  logic                  alu_go;
  logic [WIDTH-1:0]      alu_left, alu_right, alu_add_out, alu_mul_out;
  logic                  resp_valid, resp_ready;
  logic [IDW-1:0]        resp_id;
  logic [WIDTH-1:0]      resp_data;

  logic [NREQ-1:0]  rv, rop, gmask;
  logic [WIDTH-1:0] rl [NREQ];
  logic [WIDTH-1:0] rr [NREQ];
  bit auto_mode;

  assign req_valid   = rv;
  assign req_op      = rop;
  assign alu_add_out = alu_left + alu_right;
  assign alu_mul_out = alu_left * alu_right;
  for (genvar i = 0; i < NREQ; i++) begin : g_pack
    assign req_left[i*WIDTH +: WIDTH]  = rl[i];
    assign req_right[i*WIDTH +: WIDTH] = rr[i];
  end

  shared_alu_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_left(req_left), .req_right(req_right),
    .alu_go(alu_go), .alu_left(alu_left), .alu_right(alu_right),
    .alu_add_out(alu_add_out), .alu_mul_out(alu_mul_out),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_data(resp_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  typedef enum {M_IDLE, M_EXEC, M_RESP} mstate_t;
  typedef struct {logic [IDW-1:0] id; logic [WIDTH-1:0] data;} exp_t;

  mstate_t          m_state = M_IDLE;
  int               m_ptr = 0;
  int               mg;
  int               cyc = 0;
  logic [WIDTH-1:0] m_l = '0, m_r = '0, mexp;
  exp_t             sb[$];
  int               gorder[$];
  int               gcycle[$];
  int               rcycle[$];
  logic [WIDTH-1:0] rdata[$];

  // Reference model: round-robin grant, 3-phase sequencing, scoreboard compare.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      m_state = M_IDLE;
      m_ptr   = 0;
      m_l     = '0;
      m_r     = '0;
      sb.delete();
      check_val("rst_req_ready", req_ready, 0);
      check_val("rst_alu_go", alu_go, 0);
      check_val("rst_resp_valid", resp_valid, 0);
      check_val("rst_alu_left", alu_left, 0);
    end else begin
      case (m_state)
        M_IDLE: begin
          mg = -1;
          for (int k = 0; k < NREQ; k++)
            if (mg < 0 && rv[(m_ptr + k) % NREQ]) mg = (m_ptr + k) % NREQ;
          check_val("idle_alu_go", alu_go, 0);
          check_val("idle_resp_valid", resp_valid, 0);
          check_val("idle_alu_left_hold", alu_left, m_l);
          check_val("idle_alu_right_hold", alu_right, m_r);
          if (mg >= 0) begin
            check_val("grant", req_ready, 64'(1) << mg);
            mexp = rop[mg] ? rl[mg] * rr[mg] : rl[mg] + rr[mg];
            sb.push_back('{IDW'(mg), mexp});
            gorder.push_back(mg);
            gcycle.push_back(cyc);
            m_l       = rl[mg];
            m_r       = rr[mg];
            m_ptr     = (mg + 1) % NREQ;
            gmask[mg] = 1'b1;
            m_state   = M_EXEC;
          end else begin
            check_val("no_grant", req_ready, 0);
          end
        end
        M_EXEC: begin
          check_val("exec_alu_go", alu_go, 1);
          check_val("exec_alu_left", alu_left, m_l);
          check_val("exec_alu_right", alu_right, m_r);
          check_val("exec_req_ready", req_ready, 0);
          check_val("exec_resp_valid", resp_valid, 0);
          m_state = M_RESP;
        end
        M_RESP: begin
          check_val("resp_valid", resp_valid, 1);
          check_val("resp_req_ready", req_ready, 0);
          check_val("resp_alu_go", alu_go, 0);
          if (sb.size() > 0) begin
            check_val("resp_id", resp_id, sb[0].id);
            check_val("resp_data", resp_data, sb[0].data);
          end else begin
            check_val("resp_unexpected", resp_valid, 0);
          end
          if (resp_ready) begin
            if (sb.size() > 0) void'(sb.pop_front());
            rdata.push_back(resp_data);
            rcycle.push_back(cyc);
            m_state = M_IDLE;
          end
        end
        default: m_state = M_IDLE;
      endcase
    end
  end

  // Requesters: drop (or, in auto mode, immediately replace) an accepted operation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (gmask[i]) begin
          if (auto_mode) begin
            rop[i] = 1'($urandom_range(0, 1));
            rl[i]  = $urandom;
            rr[i]  = $urandom;
          end else begin
            rv[i] = 1'b0;
          end
        end
      end
      gmask = '0;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic post(input int i, input logic op, input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r);
    rop[i] = op;
    rl[i]  = l;
    rr[i]  = r;
    rv[i]  = 1'b1;
  endtask

  task automatic wait_quiet(input string tag);
    int n;
    n = 0;
    while (!(rv == 0 && m_state == M_IDLE && sb.size() == 0) && n < 200) begin
      step(1);
      n++;
    end
    check_val(tag, (rv == 0 && m_state == M_IDLE && sb.size() == 0), 1);
  endtask

  initial begin
    int base;
    int n;
    logic [WIDTH-1:0] held;
    rv = '0; rop = '0; gmask = '0; auto_mode = 1'b0;
    for (int i = 0; i < NREQ; i++) begin rl[i] = '0; rr[i] = '0; end
    resp_ready = 1'b1;
    reset = 1'b1;
    step(3);
    check_val("rst_resp_id", resp_id, 0);
    check_val("rst_resp_data", resp_data, 0);
    reset = 1'b0;
    step(1);

    // Single add from requester 2
    post(2, 1'b0, 32'd7, 32'd5);
    wait_quiet("t1_quiet");
    check_val("t1_grant_id", gorder[$], 2);
    check_val("t1_data", rdata[$], 32'd12);
    check_val("t1_latency", rcycle[$] - gcycle[$], 2);

    // Wrapping multiplies from requester 0
    post(0, 1'b1, 32'h0001_0000, 32'h0001_0000);
    wait_quiet("t2a_quiet");
    check_val("t2a_data", rdata[$], 32'h0);
    post(0, 1'b1, 32'd3, 32'hFFFF_FFFF);
    wait_quiet("t2b_quiet");
    check_val("t2b_data", rdata[$], 32'hFFFF_FFFD);

    // Requester 3 wraps the pointer; 0 then beats 3
    post(3, 1'b0, 32'd1, 32'd2);
    wait_quiet("t6a_quiet");
    base = gorder.size();
    post(3, 1'b0, 32'd10, 32'd20);
    post(0, 1'b1, 32'd6, 32'd7);
    wait_quiet("t6b_quiet");
    check_val("t6_first", gorder[base], 0);
    check_val("t6_second", gorder[base + 1], 3);

    // Backpressure on the response channel
    resp_ready = 1'b0;
    base = gorder.size();
    post(1, 1'b1, 32'h1234, 32'h10);
    post(3, 1'b0, 32'hFFFF_FFFF, 32'd2);
    n = 0;
    while (m_state != M_RESP && n < 20) begin step(1); n++; end
    held = resp_data;
    step(5);
    check_val("t4_hold_data", resp_data, held);
    check_val("t4_hold_valid", resp_valid, 1);
    resp_ready = 1'b1;
    wait_quiet("t4_quiet");
    check_val("t4_first", gorder[base], 1);
    check_val("t4_second", gorder[base + 1], 3);
    check_val("t4_data3", rdata[$], 32'd1);

    // All requesters continuously valid
    base = gorder.size();
    auto_mode = 1'b1;
    for (int i = 0; i < NREQ; i++) post(i, i[0], 32'(i * 11 + 1), 32'(i + 3));
    step(40);
    auto_mode = 1'b0;
    wait_quiet("t3_quiet");
    for (int k = 0; k < 6; k++) check_val("t3_order", gorder[base + k], k % NREQ);
    for (int k = 1; k < 6; k++) check_val("t3_spacing", gcycle[base + k] - gcycle[base + k - 1], 3);

    // Reset in EXEC drops the operation and restarts arbitration at 0
    post(3, 1'b0, 32'd100, 32'd200);
    n = 0;
    while (m_state != M_EXEC && n < 20) begin step(1); n++; end
    check_val("t5_in_exec", alu_go, 1);
    #2;
    reset = 1'b1;
    #1;
    check_val("t5_go", alu_go, 0);
    check_val("t5_ready", req_ready, 0);
    check_val("t5_valid", resp_valid, 0);
    check_val("t5_left", alu_left, 0);
    check_val("t5_right", alu_right, 0);
    check_val("t5_data", resp_data, 0);
    step(2);
    reset = 1'b0;
    step(1);
    base = gorder.size();
    n = rdata.size();
    post(3, 1'b0, 32'd1, 32'd1);
    post(0, 1'b0, 32'd2, 32'd2);
    wait_quiet("t5_quiet");
    check_val("t5_first", gorder[base], 0);
    check_val("t5_second", gorder[base + 1], 3);
    check_val("t5_resp_count", rdata.size() - n, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
